// File: rtl/soc_decode_bb.sv
// BackBone single-master to multi-slave address decoder.
// Routes each access to one slave by address and returns read data after a fixed latency.
module soc_decode_bb #(
  parameter int SLAVES       = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter logic [SLAVES-1:0][ADDR_WIDTH-1:0] S_BASE = '0,
  parameter logic [SLAVES-1:0][ADDR_WIDTH-1:0] S_MASK = '0,
  parameter int READ_LATENCY = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [ADDR_WIDTH-1:0]               m_addr_i,
  input  logic [DATA_WIDTH-1:0]               m_din_i,
  input  logic                                m_en_i,
  input  logic                                m_we_i,
  output logic [DATA_WIDTH-1:0]               m_dout_o,
  output logic                                m_rvalid_o,
  output logic                                m_err_o,
  output logic [7:0]                          err_cnt_o,
  output logic [SLAVES-1:0][ADDR_WIDTH-1:0]   s_addr_o,
  output logic [SLAVES-1:0][DATA_WIDTH-1:0]   s_din_o,
  output logic [SLAVES-1:0]                   s_en_o,
  output logic [SLAVES-1:0]                   s_we_o,
  input  logic [SLAVES-1:0][DATA_WIDTH-1:0]   s_dout_i
);

  localparam int LAST = READ_LATENCY - 1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [SLAVES-1:0] match;
  logic [SLAVES-1:0] sel;
  logic              found;
  logic              any_sel;

  // Decode: lowest matching index wins so sel is always one-hot or zero
  always_comb begin
    match = '0;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < SLAVES; i++) begin
      match[i] = ((m_addr_i & S_MASK[i]) == (S_BASE[i] & S_MASK[i]));
      if (match[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign any_sel  = |sel;
  assign s_addr_o = {SLAVES{m_addr_i}};
  assign s_din_o  = {SLAVES{m_din_i}};
  assign s_en_o   = {SLAVES{m_en_i}} & sel;
  assign s_we_o   = {SLAVES{m_en_i & m_we_i}} & sel;

  logic [READ_LATENCY-1:0]             rd_p;
  logic [READ_LATENCY-1:0]             err_p;
  logic [READ_LATENCY-1:0][SLAVES-1:0] sel_p;

  // Return pipeline: free-running shift, no stall since the bus has no backpressure
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_p  <= '0;
      err_p <= '0;
      sel_p <= '0;
    end else begin
      rd_p[0]  <= m_en_i & ~m_we_i & any_sel;
      err_p[0] <= m_en_i & ~any_sel;
      sel_p[0] <= sel;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_p[i]  <= rd_p[i-1];
        err_p[i] <= err_p[i-1];
        sel_p[i] <= sel_p[i-1];
      end
    end
  end

  // Output stage: each return uses the select captured with its own request
  always_comb begin
    m_dout_o = '0;
    if (rd_p[LAST]) begin
      for (int i = 0; i < SLAVES; i++) begin
        if (sel_p[LAST][i]) m_dout_o = m_dout_o | s_dout_i[i];
      end
    end
  end

  assign m_rvalid_o = rd_p[LAST];
  assign m_err_o    = err_p[LAST];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_o <= 8'h00;
    end else if (err_p[LAST]) begin
      err_cnt_o <= sat_inc(err_cnt_o);
    end
  end

endmodule

// File: tb/tb_soc_decode_bb.sv
// Directed bench for soc_decode_bb: table of single accesses plus hand sequences
// for back-to-back reads, counter saturation and asynchronous reset.
module tb_soc_decode_bb;

  localparam logic [1:0][31:0] BASE = {32'h8000_0000, 32'h0000_0000};
  localparam logic [1:0][31:0] MASK = {32'hF000_0000, 32'hF000_0000};

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       m_addr, m_din, m_dout;
  logic              m_en, m_we, m_rvalid, m_err;
  logic [7:0]        err_cnt;
  logic [1:0][31:0]  s_addr, s_din, s_dout;
  logic [1:0]        s_en, s_we;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  soc_decode_bb #(
    .SLAVES(2), .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .S_BASE(BASE), .S_MASK(MASK), .READ_LATENCY(1)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_addr_i(m_addr), .m_din_i(m_din), .m_en_i(m_en), .m_we_i(m_we),
    .m_dout_o(m_dout), .m_rvalid_o(m_rvalid), .m_err_o(m_err), .err_cnt_o(err_cnt),
    .s_addr_o(s_addr), .s_din_o(s_din), .s_en_o(s_en), .s_we_o(s_we),
    .s_dout_i(s_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
    logic        en;
    logic        we;
    logic [31:0] sd0;
    logic [31:0] sd1;
    logic [1:0]  xen;
    logic [1:0]  xwe;
    logic        xrv;
    logic        xerr;
    logic [31:0] xdout;
  } vec_t;

  vec_t v[6];

  initial begin
    v[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, 2'b01, 2'b01, 1'b0, 1'b0, 32'h0};
    v[1] = '{32'h8000_0004, 32'h0000_0000, 1'b1, 1'b0, 32'h5555_5555, 32'h1234_5678, 2'b10, 2'b00, 1'b1, 1'b0, 32'h1234_5678};
    v[2] = '{32'h4000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h3333_3333, 32'h4444_4444, 2'b00, 2'b00, 1'b0, 1'b1, 32'h0};
    v[3] = '{32'h8000_0000, 32'h0BAD_F00D, 1'b0, 1'b1, 32'h6666_6666, 32'h7777_7777, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0};
    v[4] = '{32'hF000_0000, 32'hABCD_0000, 1'b1, 1'b1, 32'h8888_8888, 32'h9999_9999, 2'b00, 2'b00, 1'b0, 1'b1, 32'h0};
    v[5] = '{32'h0000_0100, 32'h0000_0000, 1'b1, 1'b0, 32'hCAFE_0001, 32'hFFFF_0000, 2'b01, 2'b00, 1'b1, 1'b0, 32'hCAFE_0001};

    rst = 1'b1; m_addr = '0; m_din = '0; m_en = 1'b0; m_we = 1'b0; s_dout = '0;
    #2;
    chk("reset_rvalid", {63'd0, m_rvalid}, 64'd0);
    chk("reset_err", {63'd0, m_err}, 64'd0);
    chk("reset_dout", {32'd0, m_dout}, 64'd0);
    chk("reset_cnt", {56'd0, err_cnt}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      m_addr = v[k].addr; m_din = v[k].din; m_en = v[k].en; m_we = v[k].we;
      #1;
      chk($sformatf("v%0d_cnt", k), {56'd0, err_cnt}, 64'(exp_cnt));
      chk($sformatf("v%0d_s_en", k), {62'd0, s_en}, {62'd0, v[k].xen});
      chk($sformatf("v%0d_s_we", k), {62'd0, s_we}, {62'd0, v[k].xwe});
      chk($sformatf("v%0d_s_din0", k), {32'd0, s_din[0]}, {32'd0, v[k].din});
      chk($sformatf("v%0d_s_addr1", k), {32'd0, s_addr[1]}, {32'd0, v[k].addr});
      @(posedge clk);
      #1;
      m_en = 1'b0; m_we = 1'b0;
      s_dout[0] = v[k].sd0; s_dout[1] = v[k].sd1;
      #1;
      chk($sformatf("v%0d_rvalid", k), {63'd0, m_rvalid}, {63'd0, v[k].xrv});
      chk($sformatf("v%0d_err", k), {63'd0, m_err}, {63'd0, v[k].xerr});
      chk($sformatf("v%0d_dout", k), {32'd0, m_dout}, {32'd0, v[k].xdout});
      if (v[k].xerr) exp_cnt++;
    end

    // back-to-back reads to slave 0 then slave 1
    @(posedge clk); #1;
    m_addr = 32'h0000_0000; m_en = 1'b1; m_we = 1'b0;
    @(posedge clk); #1;
    m_addr = 32'h8000_0000;
    s_dout[0] = 32'h0000_000A; s_dout[1] = 32'h0000_FFFF;
    #1;
    chk("b2b_first_rvalid", {63'd0, m_rvalid}, 64'd1);
    chk("b2b_first_dout", {32'd0, m_dout}, 64'h0000_000A);
    chk("b2b_second_s_en", {62'd0, s_en}, 64'd2);
    @(posedge clk); #1;
    m_en = 1'b0;
    s_dout[0] = 32'h0000_EEEE; s_dout[1] = 32'h0000_000B;
    #1;
    chk("b2b_second_rvalid", {63'd0, m_rvalid}, 64'd1);
    chk("b2b_second_dout", {32'd0, m_dout}, 64'h0000_000B);
    @(posedge clk); #2;
    chk("b2b_idle_rvalid", {63'd0, m_rvalid}, 64'd0);
    chk("b2b_cnt", {56'd0, err_cnt}, 64'(exp_cnt));

    // 300 consecutive unmapped reads saturate the counter
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      m_addr = 32'h4000_0000; m_en = 1'b1; m_we = 1'b0;
      #1;
      if (i > 0) chk($sformatf("sat_err_%0d", i), {63'd0, m_err}, 64'd1);
      chk($sformatf("sat_rvalid_%0d", i), {63'd0, m_rvalid}, 64'd0);
    end
    @(posedge clk); #1;
    m_en = 1'b0;
    #1;
    chk("sat_err_last", {63'd0, m_err}, 64'd1);
    chk("sat_dout", {32'd0, m_dout}, 64'd0);
    @(posedge clk); #2;
    chk("sat_err_after", {63'd0, m_err}, 64'd0);
    chk("sat_cnt", {56'd0, err_cnt}, 64'hFF);

    // asynchronous reset in the return cycle of a read drops the return
    @(posedge clk); #1;
    m_addr = 32'h8000_0010; m_en = 1'b1; m_we = 1'b0;
    @(posedge clk); #1;
    m_en = 1'b0; s_dout[1] = 32'h7E57_7E57;
    rst = 1'b1;
    #1;
    chk("rst_mid_rvalid", {63'd0, m_rvalid}, 64'd0);
    chk("rst_mid_err", {63'd0, m_err}, 64'd0);
    chk("rst_mid_cnt", {56'd0, err_cnt}, 64'd0);
    chk("rst_mid_dout", {32'd0, m_dout}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #2;
    chk("rst_after_rvalid", {63'd0, m_rvalid}, 64'd0);
    #1;
    m_addr = 32'h0000_0020; m_en = 1'b1;
    @(posedge clk); #1;
    m_en = 1'b0; s_dout[0] = 32'h0102_0304;
    #1;
    chk("post_rst_rvalid", {63'd0, m_rvalid}, 64'd1);
    chk("post_rst_dout", {32'd0, m_dout}, 64'h0102_0304);
    chk("post_rst_cnt", {56'd0, err_cnt}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
